// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-lane stall vectors, exception/ertn flush
// sequencing with a redirect PC, IDLE handling and a sticky stall watchdog.
module pipe_ctrl #(
  parameter int          ISSUE_WIDTH  = 2,
  parameter int          STAGES       = 7,
  parameter int          ID_STAGE     = 2,
  parameter int          EX_STAGE     = 4,
  parameter int          EXC_W        = 2,
  parameter logic [31:0] EXC_ENTRY    = 32'h0000000C,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          LOCKSTEP     = 1,
  parameter int          STALL_LIMIT  = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ISSUE_WIDTH-1:0]        stallreq_id_i,
  input  logic [ISSUE_WIDTH-1:0]        stallreq_ex_i,
  input  logic [ISSUE_WIDTH*EXC_W-1:0]  excepttype_i,
  input  logic                          ertn_i,
  input  logic [31:0]                   era_i,
  input  logic                          idle_req_i,
  input  logic                          int_pending_i,
  output logic [ISSUE_WIDTH*STAGES-1:0] stall_o,
  output logic                          flush_o,
  output logic [31:0]                   new_pc_o,
  output logic                          idle_o,
  output logic                          stall_timeout_o
);

  localparam int SW = ISSUE_WIDTH * STAGES;
  localparam logic [STAGES-1:0] EX_MASK = {STAGES{1'b1}} >> (STAGES - 1 - EX_STAGE);
  localparam logic [STAGES-1:0] ID_MASK = {STAGES{1'b1}} >> (STAGES - 1 - ID_STAGE);

  typedef enum logic [1:0] {RUN, FLUSH, IDLE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  fcnt_reg, fcnt_next;
  logic [31:0] new_pc_reg, new_pc_next;
  logic [15:0] wd_reg, wd_next;
  logic        timeout_reg, timeout_next;

  logic [ISSUE_WIDTH-1:0] lane_exc;
  logic [STAGES-1:0]      lane_stall [ISSUE_WIDTH];
  logic [STAGES-1:0]      stall_or;
  logic [SW-1:0]          run_stall;
  logic                   exc_any;
  logic                   run_stalled;

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
      assign lane_exc[gi]   = |excepttype_i[gi*EXC_W +: EXC_W];
      assign lane_stall[gi] = stallreq_ex_i[gi] ? EX_MASK :
                              stallreq_id_i[gi] ? ID_MASK : '0;
      // Lockstep lanes all freeze together on the union of every lane's request.
      assign run_stall[gi*STAGES +: STAGES] = (LOCKSTEP != 0) ? stall_or : lane_stall[gi];
    end
  endgenerate

  always_comb begin
    stall_or = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) stall_or = stall_or | lane_stall[k];
  end

  // Every lane redirects to the same handler, so only "any lane faulted" matters here.
  assign exc_any = |lane_exc;

  always_comb begin
    state_next  = state_reg;
    fcnt_next   = fcnt_reg;
    new_pc_next = new_pc_reg;
    stall_o     = '0;
    case (state_reg)
      RUN: begin
        if (exc_any) begin
          state_next  = FLUSH;
          fcnt_next   = 4'(FLUSH_CYCLES - 1);
          new_pc_next = EXC_ENTRY;
        end else if (ertn_i) begin
          state_next  = FLUSH;
          fcnt_next   = 4'(FLUSH_CYCLES - 1);
          new_pc_next = era_i;
        end else begin
          stall_o = run_stall;
          if (idle_req_i) state_next = IDLE;
        end
      end
      FLUSH: begin
        if (fcnt_reg == 4'd0) state_next = RUN;
        else                  fcnt_next  = fcnt_reg - 4'd1;
      end
      IDLE: begin
        stall_o = '1;
        if (int_pending_i) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign run_stalled  = (state_reg == RUN) && (|stall_o);
  assign wd_next      = !run_stalled ? 16'd0 :
                        (wd_reg == 16'hFFFF) ? wd_reg : wd_reg + 16'd1;
  assign timeout_next = timeout_reg | (run_stalled && (wd_next == 16'(STALL_LIMIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      fcnt_reg    <= 4'd0;
      new_pc_reg  <= 32'd0;
      wd_reg      <= 16'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fcnt_reg    <= fcnt_next;
      new_pc_reg  <= new_pc_next;
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end

  assign flush_o         = (state_reg == FLUSH);
  assign new_pc_o        = flush_o ? new_pc_reg : 32'd0;
  assign idle_o          = (state_reg == IDLE);
  assign stall_timeout_o = timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a default instance and a non-lockstep instance
// (FLUSH_CYCLES=3, STALL_LIMIT=8) share the same stimulus.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  id_req = '0, ex_req = '0;
  logic [3:0]  exc = '0;
  logic        ertn = 1'b0, idle_req = 1'b0, int_pend = 1'b0;
  logic [31:0] era = '0;

  logic [13:0] stall0, stall1;
  logic        flush0, flush1, idle0, idle1, to0, to1;
  logic [31:0] pc0, pc1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  localparam logic [13:0] ONES = 14'h3FFF;

  always #5 clk = ~clk;

  pipe_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .stallreq_id_i(id_req), .stallreq_ex_i(ex_req),
    .excepttype_i(exc), .ertn_i(ertn), .era_i(era), .idle_req_i(idle_req),
    .int_pending_i(int_pend), .stall_o(stall0), .flush_o(flush0), .new_pc_o(pc0),
    .idle_o(idle0), .stall_timeout_o(to0)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .LOCKSTEP(0), .STALL_LIMIT(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stallreq_id_i(id_req), .stallreq_ex_i(ex_req),
    .excepttype_i(exc), .ertn_i(ertn), .era_i(era), .idle_req_i(idle_req),
    .int_pending_i(int_pend), .stall_o(stall1), .flush_o(flush1), .new_pc_o(pc1),
    .idle_o(idle1), .stall_timeout_o(to1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: obs = 32'(stall0);
      1: obs = 32'(flush0);
      2: obs = pc0;
      3: obs = 32'(idle0);
      4: obs = 32'(to0);
      5: obs = 32'(stall1);
      6: obs = 32'(flush1);
      7: obs = pc1;
      8: obs = 32'(idle1);
      9: obs = 32'(to1);
      default: obs = 32'hDEADBEEF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge.
  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic drive(input logic [1:0] id, input logic [1:0] ex, input logic [3:0] ec,
                       input logic er, input logic [31:0] pc, input logic idl, input logic ip);
    @(posedge clk);
    #1;
    id_req = id; ex_req = ex; exc = ec; ertn = er; era = pc; idle_req = idl; int_pend = ip;
    $display("drive id=%b ex=%b exc=%b ertn=%b era=%h idle=%b int=%b", id, ex, ec, er, pc, idl, ip);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    #12;
    check("rst_flush", 32'(flush0), 32'd0);
    check("rst_pc", pc0, 32'd0);
    check("rst_idle", 32'(idle0), 32'd0);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_to", 32'(to0), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Stall vectors: lockstep vs independent lanes
    drive(2'b00, 2'b10, 4'h0, 0, 32'h0, 0, 0);
    push_exp("ex_lane1_ls", 0, 32'h0F9F); push_exp("ex_lane1_ind", 5, 32'h0F80);
    drain();
    drive(2'b01, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("id_lane0_ls", 0, 32'h0387); push_exp("id_lane0_ind", 5, 32'h0007);
    drain();
    drive(2'b10, 2'b01, 4'h0, 0, 32'h0, 0, 0);
    push_exp("mix_ls", 0, 32'h0F9F); push_exp("mix_ind", 5, 32'h039F);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("nostall", 0, 32'h0); push_exp("nostall1", 5, 32'h0);
    drain();

    // Exception on both lanes; stall suppressed in the accept cycle
    drive(2'b00, 2'b11, 4'b1001, 0, 32'h0, 0, 0);
    push_exp("exc_supp0", 0, 32'h0); push_exp("exc_supp1", 5, 32'h0);
    push_exp("exc_noflush_yet", 1, 32'd0);
    drain();
    // In FLUSH: stall zero, ertn ignored
    drive(2'b00, 2'b11, 4'h0, 1, 32'h55555550, 0, 0);
    push_exp("exc_flush0", 1, 32'd1); push_exp("exc_pc0", 2, 32'h0000000C);
    push_exp("flush_stall0", 0, 32'h0);
    push_exp("exc_flush1", 6, 32'd1); push_exp("exc_pc1", 7, 32'h0000000C);
    push_exp("flush_stall1", 5, 32'h0);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("flush_end0", 1, 32'd0); push_exp("pc_zero0", 2, 32'd0);
    push_exp("flush1_c2", 6, 32'd1); push_exp("pc1_c2", 7, 32'h0000000C);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("ertn_ignored0", 1, 32'd0); push_exp("flush1_c3", 6, 32'd1);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("flush1_end", 6, 32'd0); push_exp("pc1_zero", 7, 32'd0);
    drain();

    // ertn beats idle_req
    drive(2'b00, 2'b00, 4'h0, 1, 32'h1C000100, 1, 0);
    push_exp("ertn_noflush_yet", 1, 32'd0);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("ertn_flush0", 1, 32'd1); push_exp("ertn_pc0", 2, 32'h1C000100);
    push_exp("ertn_noidle0", 3, 32'd0);
    push_exp("ertn_flush1", 6, 32'd1); push_exp("ertn_pc1", 7, 32'h1C000100);
    drain();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
      push_exp("ertn_after_idle0", 3, 32'd0); push_exp("ertn_after_flush0", 1, 32'd0);
      push_exp("ertn_flush1_run", 6, (i < 2) ? 32'd1 : 32'd0);
      drain();
    end

    // IDLE entry, exception ignored, wake on interrupt
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 1, 0);
    push_exp("idle_req_cycle", 3, 32'd0);
    drain();
    drive(2'b00, 2'b00, 4'b0001, 0, 32'h0, 0, 0);
    push_exp("idle0", 3, 32'd1); push_exp("idle_stall0", 0, 32'(ONES));
    push_exp("idle1", 8, 32'd1); push_exp("idle_stall1", 5, 32'(ONES));
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 1);
    push_exp("idle_exc_ignored", 1, 32'd0); push_exp("idle_still", 3, 32'd1);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("wake_idle0", 3, 32'd0); push_exp("wake_stall0", 0, 32'h0);
    push_exp("wake_flush0", 1, 32'd0);
    drain();

    // Watchdog on the STALL_LIMIT=8 instance
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 2'b00, 4'h0, 0, 32'h0, 0, 0);
      push_exp("wd_pre1", 9, 32'd0); push_exp("wd_pre0", 4, 32'd0);
      drain();
    end
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("wd_set1", 9, 32'd1); push_exp("wd_def0", 4, 32'd0);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("wd_sticky1", 9, 32'd1);
    drain();

    // Async reset in the 2nd cycle of a 3-cycle flush
    drive(2'b00, 2'b00, 4'b0100, 0, 32'h0, 0, 0);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("rf_flush1_c1", 6, 32'd1); push_exp("rf_pc1_c1", 7, 32'h0000000C);
    drain();
    @(posedge clk);
    #1;
    check("rf_flush1_c2", 32'(flush1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rf_abort_flush1", 32'(flush1), 32'd0);
    check("rf_abort_pc1", pc1, 32'd0);
    check("rf_abort_to1", 32'(to1), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("rf_run_flush1", 6, 32'd0); push_exp("rf_run_idle1", 8, 32'd0);
    push_exp("rf_run_flush0", 1, 32'd0);
    drain();
    drive(2'b00, 2'b00, 4'h0, 0, 32'h0, 0, 0);
    push_exp("rf_run2_flush1", 6, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ISSUE_WIDTH, default 2, number of issue lanes (1..4).
REQ-002 Parameter STAGES, default 7, stall-vector width per lane; bit 0 = PC stage.
REQ-003 Parameter ID_STAGE, default 2, highest stage frozen by a decode stall.
REQ-004 Parameter EX_STAGE, default 4, highest stage frozen by an execute stall.
REQ-005 Parameter EXC_W, default 2, exception-code width per lane.
REQ-006 Parameter EXC_ENTRY, default 32'h0000000C, exception handler PC.
REQ-007 Parameter FLUSH_CYCLES, default 1, flush pulse length (1..15).
REQ-008 Parameter LOCKSTEP, default 1; 1 = all lanes share one stall vector, 0 = independent per lane.
REQ-009 Parameter STALL_LIMIT, default 1023, watchdog threshold in cycles.
REQ-010 clk  in  1  sole clock, rising edge.
REQ-011 rst_n  in  1  asynchronous active-low reset.
REQ-012 stallreq_id_i  in  ISSUE_WIDTH  per-lane decode stall request.
REQ-013 stallreq_ex_i  in  ISSUE_WIDTH  per-lane execute stall request.
REQ-014 excepttype_i  in  ISSUE_WIDTH*EXC_W  per-lane exception code, lane 0 in LSBs; 0 = none.
REQ-015 ertn_i  in  1  exception-return request; era_i  in  32  return PC.
REQ-016 idle_req_i  in  1  IDLE instruction retired; int_pending_i  in  1  interrupt pending.
REQ-017 stall_o  out  ISSUE_WIDTH*STAGES  per-lane stall vectors, lane 0 in LSBs.
REQ-018 flush_o  out  1  pipeline flush; new_pc_o  out  32  redirect PC, valid while flush_o=1.
REQ-019 idle_o  out  1  core in idle state; stall_timeout_o  out  1  sticky watchdog flag.

Function
REQ-020 FSM states RUN, FLUSH, IDLE; reset state RUN.
REQ-021 In RUN, any nonzero lane code -> FLUSH next edge; lowest-numbered nonzero lane wins; new_pc register loaded with EXC_ENTRY.
REQ-022 In RUN with no exception and ertn_i=1 -> FLUSH; new_pc register loaded with era_i sampled that cycle.
REQ-023 In RUN with no exception, no ertn_i, idle_req_i=1 -> IDLE.
REQ-024 Priority same cycle: exception > ertn_i > idle_req_i.
REQ-025 FLUSH: flush_o=1 and new_pc_o held stable for exactly FLUSH_CYCLES cycles (down-counter), then RUN; flush_o is registered, asserting one cycle after the triggering request.
REQ-026 In FLUSH, excepttype_i, ertn_i, idle_req_i ignored; stall_o all zero.
REQ-027 IDLE: idle_o=1, stall_o all ones in every lane; int_pending_i=1 -> RUN next edge (interrupt then arrives via excepttype_i); exceptions ignored while in IDLE.
REQ-028 RUN stall per lane k: stallreq_ex_i[k] -> bits [EX_STAGE:0] set; else stallreq_id_i[k] -> bits [ID_STAGE:0] set; else zero; combinational from inputs.
REQ-029 LOCKSTEP=1: every lane receives the bitwise OR of all lanes' RUN vectors.
REQ-030 RUN stall suppressed (zero) in the cycle an exception or ertn_i is accepted.
REQ-031 new_pc_o = 0 when flush_o=0.
REQ-032 Watchdog: 16-bit counter increments each cycle any stall_o bit is set in RUN, clears when none set or state not RUN; saturates at 16'hFFFF.
REQ-033 Counter reaching STALL_LIMIT sets stall_timeout_o; cleared only by reset.

Reset
REQ-034 rst_n=0 asynchronously forces: state RUN, flush_o=0, new_pc_o=0, idle_o=0, stall_o=0, watchdog=0, stall_timeout_o=0, flush counter=0.
REQ-035 Reset mid-FLUSH or mid-IDLE aborts immediately; first cycle after release is RUN with no pending flush.

Verification
REQ-036 Defaults, lane1 stallreq_ex_i=1 only -> stall_o = {7'b0011111,7'b0011111}; LOCKSTEP=0 -> {7'b0011111,7'b0000000}.
REQ-037 excepttype_i lane0=2'b01, lane1=2'b10 same cycle -> next cycle flush_o=1, new_pc_o=32'h0000000C for 1 cycle, stall_o=0.
REQ-038 ertn_i=1, era_i=32'h1C000100, idle_req_i=1 same cycle -> flush_o=1, new_pc_o=32'h1C000100; IDLE not entered.
REQ-039 idle_req_i pulse -> idle_o=1, stall_o all ones; exception during IDLE ignored; int_pending_i=1 -> idle_o=0 next cycle.
REQ-040 STALL_LIMIT=8, stallreq_id_i held -> stall_timeout_o rises after 8 stalled cycles, stays 1 after stall drops.
REQ-041 FLUSH_CYCLES=3, exception, rst_n low in 2nd flush cycle -> flush_o=0 immediately, RUN after release.
